// File: rtl/uart_tx.sv
// Bus-programmed UART transmitter: a small byte FIFO feeding an 8N1 serializer.
// Optional even-parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0]   ADDR_TXDATA = 32'h0000_0008;
  localparam logic [31:0]   ADDR_STATUS = 32'h0000_000C;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [31:0]   r_rd;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_baud_done;
  logic [4:0] w_count_ext;
  logic       w_unused;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_push      = !rst && we && (addr == ADDR_TXDATA) && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_count_ext = 5'(r_count);
  assign w_unused    = ^{wd[31:8], w_count_ext[4]};

  // Storage needs no reset: pointers and occupancy alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
    end else if (addr == ADDR_STATUS) begin
      r_rd <= {26'b0, w_count_ext[3:0], w_empty, w_full};
    end else begin
      r_rd <= '0;
    end
  end

  // tx is registered from the current state, so the line lags each decision by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_idx  <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
            r_par   <= ^r_mem[r_rptr];
`endif
            r_state <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_baud  <= '0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx = r_tx;
  assign rd = r_rd;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port we  input  1  bus write strobe, one cycle per write.
REQ-006 SHALL have port addr  input  32  bus byte address.
REQ-007 SHALL have port wd  input  32  bus write data.
REQ-008 SHALL have port rd  output  32  registered bus read data.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.

Function
REQ-010 SHALL decode TXDATA at 0x0000_0008 and STATUS at 0x0000_000C; no other address has any effect.
REQ-011 SHALL, on we with addr==TXDATA, push wd[7:0] into the FIFO iff the FIFO is not full at that edge; a write while full is silently dropped and state is unchanged.
REQ-012 SHALL load rd every cycle, regardless of we: STATUS -> {26'b0, count[3:0], empty, full}, where count is the FIFO occupancy, empty is bit1 and full is bit0; TXDATA and all other addresses -> 0; one-cycle read latency.
REQ-013 SHALL implement a FIFO with wrapping read/write pointers of log2(FIFO_DEPTH) bits plus an occupancy counter 0..FIFO_DEPTH.
REQ-014 SHALL accept a simultaneous push and pop in one cycle: occupancy unchanged, both pointers advance; when full, push is refused even if a pop occurs in the same cycle.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx=1; if the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: drive shift-register bits LSB first, each for CLKS_PER_BIT cycles; after bit 7, go to PARITY if enabled, else to STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE; a queued byte is popped in the first IDLE cycle, giving exactly one idle cycle between back-to-back frames.
REQ-020 SHALL count the baud counter from 0 to CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and hold it at 0 in IDLE.
REQ-021 SHALL register tx so that the line changes on the edge after the state/counter decision; the first START low appears the cycle after the pop.
REQ-022 SHALL make frame length exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.

Reset
REQ-023 SHALL, while rst is high at an edge, set tx=1, rd=0, FSM=IDLE, pointers=0, occupancy=0, baud counter=0 and bit index=0; writes in that cycle are ignored.
REQ-024 SHALL abort any frame in progress on reset, with tx returning high on that edge, and SHALL discard all queued bytes.

Configuration
REQ-025 SHALL compile the PARITY state and parity bit in only when macro UART_TX_PARITY_EN is defined.
REQ-026 With UART_TX_PARITY_EN: the PARITY state drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles between bit 7 and STOP.
REQ-027 Without UART_TX_PARITY_EN: the PARITY state is unreachable or absent and DATA goes directly to STOP; register map and all other behaviour are identical.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte: write 0x55 to 0x08 -> tx low for 4 cycles starting 2 cycles after the write edge, then data 1,0,1,0,1,0,1,0 (4 cycles each), then high; 40 cycles total (44 with parity, parity bit 0).
REQ-029 Overflow: 6 back-to-back writes 0x01..0x06 starting from empty -> only 0x01..0x05 transmitted (one popped, four queued); 0x06 dropped; STATUS read shows full=1 during the writes.
REQ-030 STATUS read: after 3 queued writes with FSM busy, read 0x0C -> rd=0x0000_000C (count=3) one cycle later; read 0x08 -> rd=0.
REQ-031 Simultaneous push/pop: a write on the exact cycle IDLE pops with occupancy 2 -> occupancy remains 2 and byte order is preserved.
REQ-032 Reset mid-frame: assert rst during DATA bit 3 of 0xA5 with 2 bytes queued -> tx=1 after the edge, STATUS=0x2 (empty), nothing further transmitted.
REQ-033 Parity build: 0x07 with UART_TX_PARITY_EN -> parity bit 1; without it -> frame of 40 cycles and no parity bit.
